product_job_ctrl: RTL and testbench
===================================

Name: product_job_ctrl

Overview:
- Job controller directly upstream of the three-operand product engine.
- Accepts three unsigned operand bytes (A, B, C) on a valid/ready stream and writes them into the shared 256x8 data memory at addresses 1..3.
- Kicks the engine via its init line, waits for done, then reads the 16-bit product from addresses 4 (high) and 5 (low).
- Presents the product on a valid/ready result stream.

Parameters:
- OP_BASE, 1, data-memory address of first operand (A); B and C follow consecutively.
- N_OPS, 3, operand bytes per job.
- RES_BASE, 4, address of result high byte; low byte at RES_BASE+1.
- START_LEN, 1, cycles eng_init is held high per job (>=1).
- TIMEOUT, 255, max WAIT cycles before abort (only with PRODUCT_TIMEOUT_EN).

Ports:
- clk  in  1  clock, all state on rising edge.
- init  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand byte valid.
- in_data  in  8  operand byte.
- in_ready  out  1  controller accepts operand.
- mem_we  out  1  data-memory write enable.
- mem_re  out  1  data-memory read enable.
- mem_addr  out  8  data-memory address.
- mem_wdata  out  8  data-memory write data.
- mem_rdata  in  8  data-memory read data, valid one cycle after mem_re.
- eng_init  out  1  init to product engine.
- eng_done  in  1  engine completion flag.
- res_valid  out  1  result valid.
- res_data  out  16  product, {mem[RES_BASE], mem[RES_BASE+1]}.
- res_ready  in  1  consumer accepts result.
- res_err  out  1  result is a timeout abort (qualified by res_valid).
- busy  out  1  high in every state except LOAD with idx=0.

Behaviour:
- Reset:
  - Async on init: state=LOAD, idx=0, res_data=0, res_valid=0, res_err=0, mem_we=0, mem_re=0, in_ready=0 while init high.
  - eng_init = init | (state==START), so the engine is reset with the controller.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, same cycle: mem_we=1, mem_addr=OP_BASE+idx, mem_wdata=in_data; idx++.
  - Accept with idx==N_OPS-1 -> START, idx=0.
  - No accept -> stay; mem_we=0.
- START:
  - eng_init=1 for exactly START_LEN cycles, then WAIT.
  - in_ready=0. eng_done ignored (it may be stale from the prior job).
- WAIT:
  - eng_done=1 -> RD_HI.
  - Stays indefinitely without the optional feature.
- RD_HI: mem_re=1, mem_addr=RES_BASE -> RD_LO.
- RD_LO: mem_re=1, mem_addr=RES_BASE+1; capture mem_rdata into res_data[15:8] -> CAP.
- CAP: capture mem_rdata into res_data[7:0] -> OUT.
- OUT:
  - res_valid=1; res_data and res_err held stable until res_ready.
  - On res_valid&res_ready -> LOAD next cycle; res_valid=0 that cycle.
- Latency, last operand accepted to res_valid: START_LEN + engine cycles + 3.
- Arithmetic: no arithmetic on operands; idx is 2 bits, never exceeds N_OPS-1, no wrap.
- Outputs when not driving:
  - mem_we/mem_re never both high.
  - mem_addr=0 and mem_wdata=0 when neither is active.
- in_valid outside LOAD: ignored, not consumed.
- Reset mid-job from any state: immediate return to LOAD with idx=0; partial operands discarded (memory contents not cleared).

Optional Feature:
- PRODUCT_TIMEOUT_EN defined:
  - 8-bit watchdog cleared on entry to WAIT, increments each WAIT cycle.
  - Reaching TIMEOUT without eng_done -> OUT with res_data=16'h0000, res_err=1, memory not read.
  - eng_done on the same cycle the count reaches TIMEOUT: done wins (normal read path, res_err=0).
- Not defined: no counter; WAIT waits forever; res_err tied 0.

Decomposition:
- product_pkg holds:
  - state enum {LOAD, START, WAIT, RD_HI, RD_LO, CAP, OUT};
  - address constants OP_BASE_DEF=1 and RES_BASE_DEF=4;
  - N_OPS_DEF=3.
- One natural sub-module: product_watchdog (clear, enable, terminal-count output), instantiated only under PRODUCT_TIMEOUT_EN.

Test Plan:
- Operands 3,5,7 with memory+engine model: three writes to addr 1,2,3; eng_init one cycle; res_data=16'h0069, res_err=0.
- Operands 255,255,255: res_data=16'h02FF (low 16 bits of 0xFD02FF); reads at addr 4 then 5.
- in_valid gaps of 2 cycles between operands: exactly 3 writes, no duplicates; res_ready low 5 cycles in OUT: res_valid and res_data held, then one handshake, back to LOAD.
- init asserted during WAIT: next cycle state LOAD, busy=0, res_valid=0, eng_init high during init; new job 2,3,4 yields 16'h0018.
- PRODUCT_TIMEOUT_EN with engine stub never raising done, TIMEOUT=10: res_valid after 10 WAIT cycles, res_err=1, res_data=0, no mem_re pulses.
- Back-to-back jobs, stale eng_done=1 during START: ignored; second job result correct.

Source files
------------

// File: rtl/product_pkg.sv
// Shared types and constants for the product job controller.
package product_pkg;

    // Controller sequence for one job
    typedef enum logic [2:0] {
        LOAD  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        RD_HI = 3'd3,
        RD_LO = 3'd4,
        CAP   = 3'd5,
        OUT   = 3'd6
    } state_t;

    // Data-memory layout shared with the product engine
    localparam logic [7:0] OP_BASE_DEF  = 8'd1;
    localparam logic [7:0] RES_BASE_DEF = 8'd4;
    localparam int         N_OPS_DEF    = 3;

endpackage

// File: rtl/product_watchdog.sv
// Watchdog for the WAIT state: counts enabled cycles and flags the cycle on
// which the count reaches TIMEOUT.
module product_watchdog #(
    parameter int W       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [W-1:0] count;

    // Cycle counter, zeroed whenever the controller is outside WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Terminal count: this enabled cycle brings the count to TIMEOUT
    assign tc = enable && (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/product_job_ctrl.sv
// Job controller in front of the three-operand product engine.
// Loads operand bytes into data memory, pulses the engine init line, waits
// for done, reads back the 16-bit product and offers it on a result stream.
// Optional macro PRODUCT_TIMEOUT_EN adds a WAIT watchdog that aborts the job
// with res_err=1 and res_data=0 when the engine never answers.
module product_job_ctrl
    import product_pkg::*;
#(
    parameter logic [7:0] OP_BASE   = OP_BASE_DEF,
    parameter int         N_OPS     = N_OPS_DEF,
    parameter logic [7:0] RES_BASE  = RES_BASE_DEF,
    parameter int         START_LEN = 1,
    parameter int         TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        init,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic        mem_re,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        eng_init,
    input  logic        eng_done,
    output logic        res_valid,
    output logic [15:0] res_data,
    input  logic        res_ready,
    output logic        res_err,
    output logic        busy
);

    localparam logic [1:0] IDX_LAST   = 2'(N_OPS - 1);
    localparam logic [7:0] START_LAST = 8'(START_LEN - 1);

    state_t     state;
    state_t     state_nx;
    logic [1:0] idx;
    logic [7:0] start_cnt;
    logic       accept;
    logic       wd_tc;

    assign accept = in_valid && in_ready;

`ifdef PRODUCT_TIMEOUT_EN
    product_watchdog #(
        .W       (8),
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (init),
        .clear  (state != WAIT),
        .enable (state == WAIT),
        .tc     (wd_tc)
    );
`else
    assign wd_tc = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a stale eng_done is only looked at from WAIT onward
    always_comb begin
        state_nx = state;
        unique case (state)
            LOAD:  if (accept && (idx == IDX_LAST)) state_nx = START;
            START: if (start_cnt == START_LAST)     state_nx = WAIT;
            WAIT: begin
                if (eng_done)   state_nx = RD_HI;
                else if (wd_tc) state_nx = OUT;
            end
            RD_HI: state_nx = RD_LO;
            RD_LO: state_nx = CAP;
            CAP:   state_nx = OUT;
            OUT:   if (res_ready) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    // Output decode; memory bus is zeroed whenever it is idle
    always_comb begin
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = 8'd0;
        mem_wdata = 8'd0;
        res_valid = 1'b0;
        unique case (state)
            LOAD: begin
                in_ready = !init;
                if (in_valid && !init) begin
                    mem_we    = 1'b1;
                    mem_addr  = OP_BASE + 8'(idx);
                    mem_wdata = in_data;
                end
            end
            RD_HI: begin
                mem_re   = 1'b1;
                mem_addr = RES_BASE;
            end
            RD_LO: begin
                mem_re   = 1'b1;
                mem_addr = RES_BASE + 8'd1;
            end
            OUT:     res_valid = 1'b1;
            default: ;
        endcase
        eng_init = init || (state == START);
        busy     = !((state == LOAD) && (idx == 2'd0));
    end

    // Operand index and START hold counter
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            idx       <= 2'd0;
            start_cnt <= 8'd0;
        end else begin
            if ((state == LOAD) && accept) begin
                idx <= (idx == IDX_LAST) ? 2'd0 : idx + 2'd1;
            end
            start_cnt <= (state == START) ? start_cnt + 8'd1 : 8'd0;
        end
    end

    // Result capture: read data lands one cycle after each mem_re
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            res_data <= 16'h0000;
            res_err  <= 1'b0;
        end else begin
            unique case (state)
                WAIT: begin
                    if (eng_done) begin
                        res_err <= 1'b0;
                    end else if (wd_tc) begin
                        res_data <= 16'h0000;
                        res_err  <= 1'b1;
                    end
                end
                RD_LO:   res_data[15:8] <= mem_rdata;
                CAP:     res_data[7:0]  <= mem_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_product_job_ctrl.sv
// Directed bench for product_job_ctrl with a data-memory and engine model.
// Build with PRODUCT_TIMEOUT_EN defined to also exercise the watchdog abort.
module tb_product_job_ctrl;

    localparam int ENG_LAT = 4;

    logic        clk = 1'b0;
    logic        init;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        eng_init;
    logic        eng_done;
    logic        res_valid;
    logic [15:0] res_data;
    logic        res_ready;
    logic        res_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    product_job_ctrl #(
        .START_LEN (1),
        .TIMEOUT   (10)
    ) dut (
        .clk       (clk),
        .init      (init),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .eng_init  (eng_init),
        .eng_done  (eng_done),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .res_err   (res_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Data memory plus product engine model (done stays high until next init)
    logic [7:0]  mem [256];
    logic [23:0] prod;
    logic [3:0]  eng_cnt;
    logic        eng_run;
    logic        eng_hang = 1'b0;

    assign prod = {16'd0, mem[1]} * {16'd0, mem[2]} * {16'd0, mem[3]};

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (eng_init) begin
            eng_cnt  <= 4'(ENG_LAT);
            eng_run  <= 1'b1;
            eng_done <= 1'b0;
        end else if (eng_run && !eng_hang) begin
            if (eng_cnt == 4'd1) begin
                mem[4]   <= prod[15:8];
                mem[5]   <= prod[7:0];
                eng_done <= 1'b1;
                eng_run  <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt - 4'd1;
            end
        end
    end

    // Bus monitor
    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    logic [7:0] rd_addr_q[$];
    int ei_cycles = 0;
    int bus_bad   = 0;

    always @(posedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
        if (mem_re) rd_addr_q.push_back(mem_addr);
        if (eng_init && !init) ei_cycles <= ei_cycles + 1;
        if ((mem_we && mem_re) || (mem_re && mem_wdata != 8'd0) ||
            (!mem_we && !mem_re && (mem_addr != 8'd0 || mem_wdata != 8'd0)))
            bus_bad <= bus_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_op(input logic [7:0] d);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_op_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic wait_result(input logic [15:0] exp, input logic exp_err,
                               input int hold, input string tag);
        int n;
        n = 0;
        while (!res_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        check({tag, "_data"}, {16'd0, res_data}, {16'd0, exp});
        check({tag, "_err"}, {31'd0, res_err}, {31'd0, exp_err});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, {31'd0, res_valid}, 32'd1);
            check({tag, "_hold_data"}, {16'd0, res_data}, {16'd0, exp});
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check({tag, "_post_valid"}, {31'd0, res_valid}, 32'd0);
        check({tag, "_post_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_job(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input int gap, input int hold, input bit stale, input bit stray,
                           input logic [15:0] exp, input string tag);
        int wb, rb, eb;
        logic [7:0] ops [3];
        ops[0] = a; ops[1] = b; ops[2] = c;
        wb = wr_addr_q.size();
        rb = rd_addr_q.size();
        eb = ei_cycles;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) repeat (gap) @(negedge clk);
            send_op(ops[i]);
        end
        if (stray) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
        end
        if (stale) begin
            @(negedge clk);
            check({tag, "_start_init"}, {31'd0, eng_init}, 32'd1);
            check({tag, "_stale_done"}, {31'd0, eng_done}, 32'd1);
        end
        wait_result(exp, 1'b0, hold, tag);
        check({tag, "_wr_n"}, wr_addr_q.size() - wb, 32'd3);
        for (int i = 0; i < 3 && wb + i < wr_addr_q.size(); i++) begin
            check({tag, "_wr_addr"}, {24'd0, wr_addr_q[wb + i]}, 32'(i + 1));
            check({tag, "_wr_data"}, {24'd0, wr_data_q[wb + i]}, {24'd0, ops[i]});
        end
        check({tag, "_rd_n"}, rd_addr_q.size() - rb, 32'd2);
        if (rd_addr_q.size() - rb == 2) begin
            check({tag, "_rd_hi"}, {24'd0, rd_addr_q[rb]}, 32'd4);
            check({tag, "_rd_lo"}, {24'd0, rd_addr_q[rb + 1]}, 32'd5);
        end
        check({tag, "_eng_init_cycles"}, ei_cycles - eb, 32'd1);
    endtask

    initial begin
        init      = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        res_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_eng_init", {31'd0, eng_init}, 32'd1);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_re", {31'd0, mem_re}, 32'd0);
        check("rst_res_data", {16'd0, res_data}, 32'd0);
        init = 1'b0;
        @(negedge clk);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_eng_init", {31'd0, eng_init}, 32'd0);

        // Basic jobs, stale done on back-to-back jobs, gaps and a held result
        run_job(8'd3, 8'd5, 8'd7, 0, 0, 1'b0, 1'b0, 16'h0069, "job357");
        run_job(8'd255, 8'd255, 8'd255, 0, 0, 1'b1, 1'b1, 16'h02FF, "job255");
        run_job(8'd1, 8'd2, 8'd3, 2, 5, 1'b1, 1'b0, 16'h0006, "job_gap_hold");
        run_job(8'd4, 8'd5, 8'd6, 0, 0, 1'b1, 1'b0, 16'h0078, "job456");

        // Reset during WAIT, then with a partial operand load
        send_op(8'd9);
        send_op(8'd9);
        send_op(8'd9);
        @(negedge clk);
        @(negedge clk);
        check("wait_eng_init", {31'd0, eng_init}, 32'd0);
        check("wait_busy", {31'd0, busy}, 32'd1);
        init = 1'b1;
        @(negedge clk);
        check("rst_wait_busy", {31'd0, busy}, 32'd0);
        check("rst_wait_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_wait_eng_init", {31'd0, eng_init}, 32'd1);
        check("rst_wait_in_ready", {31'd0, in_ready}, 32'd0);
        init = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        send_op(8'd7);
        @(negedge clk);
        check("partial_busy", {31'd0, busy}, 32'd1);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        check("partial_rst_busy", {31'd0, busy}, 32'd0);
        run_job(8'd2, 8'd3, 8'd4, 0, 0, 1'b0, 1'b0, 16'h0018, "job234");

`ifdef PRODUCT_TIMEOUT_EN
        // Engine never answers: abort after TIMEOUT WAIT cycles
        begin
            int n;
            int rb;
            eng_hang = 1'b1;
            rb = rd_addr_q.size();
            send_op(8'd1);
            send_op(8'd1);
            send_op(8'd1);
            @(negedge clk);
            n = 0;
            @(negedge clk);
            while (!res_valid && n < 100) begin
                n++;
                @(negedge clk);
            end
            check("to_wait_cycles", n, 32'd10);
            wait_result(16'h0000, 1'b1, 0, "timeout");
            check("to_no_reads", rd_addr_q.size() - rb, 32'd0);
            eng_hang = 1'b0;
        end
        run_job(8'd3, 8'd5, 8'd7, 0, 0, 1'b0, 1'b0, 16'h0069, "job_after_to");
`endif

        check("bus_rules", bus_bad, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish before 200000");
        $fatal(1, "bench time limit");
    end

endmodule
